spi_master_core: RTL and testbench
==================================

// Module: spi_master_core
// PURPOSE
// - 32-bit SPI master shift engine downstream of the Avalon control slave.
// - Accepts a one-cycle go_transfer pulse and the word on data_write_to_spi, then runs one full-duplex
//   MSB-first SPI frame.
// - Returns the received word on data_read_from_spi.
// - Reports completion by a 1->0 edge on data_pack_ready; the slave edge-detects this edge as
//   transfer_complete.
// PARAMETERS
// DATA_W    32  frame length in bits (>=2)
// CLK_DIV   4   clk cycles per SCLK half-period (>=1)
// CPOL      0   SCLK idle level
// CPHA      0   0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
// CS_SETUP  2   clk cycles with cs_n low before first SCLK edge (>=1)
// CS_HOLD   2   clk cycles with cs_n low after last SCLK edge (>=1)
// PORTS
// clk                 in   1       system clock
// reset_n             in   1       asynchronous active-low reset
// go_transfer         in   1       start pulse, sampled only in IDLE
// data_write_to_spi   in   DATA_W  tx word, latched on the cycle go_transfer is accepted
// data_read_from_spi  out  DATA_W  rx word, updated at completion, held until next completion
// data_pack_ready     out  1       high while a frame is in progress; falls at completion
// spi_sclk            out  1       SPI clock
// spi_mosi            out  1       master out
// spi_miso            in   1       master in (synchronous to spi_sclk; no resync required)
// spi_cs_n            out  1       active-low chip select
// BEHAVIOUR
// - Reset (async, immediate):
//   - spi_cs_n=1, spi_sclk=CPOL, spi_mosi=0, data_pack_ready=0, data_read_from_spi=0.
//   - FSM goes to IDLE; all counters and shift registers are cleared.
// - All outputs are driven from registers; there are no combinational paths from inputs.
// - FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
// - IDLE:
//   - cs_n=1, sclk=CPOL.
//   - When go_transfer=1: load tx shift register, set data_pack_ready<=1, clear counters, go to SETUP.
// - SETUP:
//   - cs_n=0 for CS_SETUP cycles.
//   - With CPHA=0, the MSB of tx is on mosi from SETUP entry.
// - SHIFT:
//   - A divider counts CLK_DIV cycles per half-period; sclk toggles at each terminal count.
//   - Exactly 2*DATA_W sclk edges occur per frame.
//   - The sample edge shifts miso into the rx register LSB.
//   - The shift edge presents the next tx bit on mosi.
//   - With CPHA=1, the MSB is presented on the first (leading) edge.
//   - After the final edge, sclk=CPOL and the FSM goes to HOLD.
// - HOLD:
//   - cs_n=0 for CS_HOLD cycles.
//   - On the last HOLD cycle edge, the following happen together: data_read_from_spi<=rx,
//     data_pack_ready<=0, cs_n<=1, FSM -> IDLE.
// - Latency: data_pack_ready falls exactly 1+CS_SETUP+2*DATA_W*CLK_DIV+CS_HOLD clk edges after
//   the edge that accepted go_transfer.
// - go_transfer outside IDLE is ignored and not queued.
// - go_transfer asserted in the first IDLE cycle after completion is accepted (back-to-back frames).
// - data_write_to_spi changes after acceptance do not affect the current frame.
// - Reset mid-frame aborts the frame:
//   - No completion edge is generated; data_read_from_spi returns to 0.
//   - The next go_transfer after reset starts a clean frame.
// - Counter widths: use $clog2 of each maximum (CLK_DIV, 2*DATA_W, CS_SETUP, CS_HOLD).
//   Counters must never wrap within a frame.
// TESTING
// 1. Assert reset_n=0 -> cs_n=1, sclk=0, mosi=0, data_pack_ready=0, rx=0; go_transfer during reset
//    is ignored.
// 2. Loopback (miso=mosi), defaults, tx=0xA5A5A5A5 -> 32 rising sclk edges, rx=0xA5A5A5A5,
//    data_pack_ready falls 261 clk after go.
// 3. Slave model returns 0x12345678, tx=0xDEADBEEF -> bench captures 0xDEADBEEF on mosi at sample
//    edges; rx=0x12345678.
// 4. go_transfer re-pulsed during SETUP, SHIFT and HOLD -> single frame, one falling edge of
//    data_pack_ready.
// 5. reset_n low at bit 10 of a frame -> cs_n=1 and sclk=CPOL asynchronously, no completion edge;
//    next frame with tx=0x0000FFFF loopback gives rx=0x0000FFFF.
// 6. CPOL=1, CPHA=1, CLK_DIV=1, go issued the cycle after completion -> sclk idles high, two frames
//    0x80000001 and 0x7FFFFFFE loop back correctly.

Source files
------------

// File: rtl/spi_master_core_if.sv
// Bundle of control-side handshake and SPI pin signals for spi_master_core.
// The "master" modport is the view of the SPI master core; the "slave" modport is the view of its environment.
interface spi_master_core_if #(
   parameter int DATA_W = 32
) ();
   logic              go_transfer;
   logic [DATA_W-1:0] data_write_to_spi;
   logic [DATA_W-1:0] data_read_from_spi;
   logic              data_pack_ready;
   logic              spi_sclk;
   logic              spi_mosi;
   logic              spi_miso;
   logic              spi_cs_n;

   modport master (
      input  go_transfer,
      input  data_write_to_spi,
      input  spi_miso,
      output data_read_from_spi,
      output data_pack_ready,
      output spi_sclk,
      output spi_mosi,
      output spi_cs_n
   );

   modport slave (
      output go_transfer,
      output data_write_to_spi,
      output spi_miso,
      input  data_read_from_spi,
      input  data_pack_ready,
      input  spi_sclk,
      input  spi_mosi,
      input  spi_cs_n
   );
endinterface

// File: rtl/spi_master_core.sv
// Full-duplex MSB-first SPI master shift engine: one frame per accepted go_transfer pulse,
// completion signalled by the falling edge of data_pack_ready. All outputs are registered.
module spi_master_core #(
   parameter int DATA_W   = 32,
   parameter int CLK_DIV  = 4,
   parameter int CPOL     = 0,
   parameter int CPHA     = 0,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input logic               clk,
   input logic               reset_n,
   spi_master_core_if.master bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W);
   localparam int SET_W  = $clog2(CS_SETUP + 1);
   localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(CS_SETUP);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);
   localparam logic              CPOL_L    = (CPOL != 0);
   localparam logic              CPHA_L    = (CPHA != 0);

   logic [1:0]        state_q, state_d;
   logic [DIV_W-1:0]  divCnt_q, divCnt_d;
   logic [EDGE_W-1:0] edgeCnt_q, edgeCnt_d;
   logic [SET_W-1:0]  setupCnt_q, setupCnt_d;
   logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rdData_q, rdData_d;
   logic              ready_q, ready_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              csN_q, csN_d;

   always_comb begin
      state_d    = state_q;
      divCnt_d   = divCnt_q;
      edgeCnt_d  = edgeCnt_q;
      setupCnt_d = setupCnt_q;
      holdCnt_d  = holdCnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rdData_d   = rdData_q;
      ready_d    = ready_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      csN_d      = csN_q;

      case (state_q)
         ST_IDLE: begin
            csN_d  = 1'b1;
            sclk_d = CPOL_L;
            if (bus.go_transfer) begin
               state_d    = ST_SETUP;
               ready_d    = 1'b1;
               csN_d      = 1'b0;
               divCnt_d   = '0;
               edgeCnt_d  = '0;
               setupCnt_d = '0;
               holdCnt_d  = '0;
               rx_d       = '0;
               // CPHA=0 slaves sample on the leading edge, so the MSB must already be on mosi.
               if (!CPHA_L) begin
                  mosi_d = bus.data_write_to_spi[DATA_W-1];
                  tx_d   = {bus.data_write_to_spi[DATA_W-2:0], 1'b0};
               end else begin
                  mosi_d = 1'b0;
                  tx_d   = bus.data_write_to_spi;
               end
            end
         end

         ST_SETUP: begin
            if (setupCnt_q == SET_LAST) begin
               state_d = ST_SHIFT;
            end else begin
               setupCnt_d = setupCnt_q + 1'b1;
            end
         end

         ST_SHIFT: begin
            if (divCnt_q == DIV_LAST) begin
               divCnt_d = '0;
               sclk_d   = ~sclk_q;
               // Even edge indices are leading edges; the phase decides which ones sample.
               if (edgeCnt_q[0] == CPHA_L) begin
                  rx_d = {rx_q[DATA_W-2:0], bus.spi_miso};
               end else begin
                  mosi_d = tx_q[DATA_W-1];
                  tx_d   = {tx_q[DATA_W-2:0], 1'b0};
               end
               if (edgeCnt_q == EDGE_LAST) begin
                  state_d   = ST_HOLD;
                  holdCnt_d = '0;
               end else begin
                  edgeCnt_d = edgeCnt_q + 1'b1;
               end
            end else begin
               divCnt_d = divCnt_q + 1'b1;
            end
         end

         ST_HOLD: begin
            if (holdCnt_q == HOLD_LAST) begin
               state_d  = ST_IDLE;
               rdData_d = rx_q;
               ready_d  = 1'b0;
               csN_d    = 1'b1;
               mosi_d   = 1'b0;
            end else begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         divCnt_q   <= '0;
         edgeCnt_q  <= '0;
         setupCnt_q <= '0;
         holdCnt_q  <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rdData_q   <= '0;
         ready_q    <= 1'b0;
         sclk_q     <= CPOL_L;
         mosi_q     <= 1'b0;
         csN_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         divCnt_q   <= divCnt_d;
         edgeCnt_q  <= edgeCnt_d;
         setupCnt_q <= setupCnt_d;
         holdCnt_q  <= holdCnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rdData_q   <= rdData_d;
         ready_q    <= ready_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         csN_q      <= csN_d;
      end
   end

   assign bus.data_read_from_spi = rdData_q;
   assign bus.data_pack_ready    = ready_q;
   assign bus.spi_sclk           = sclk_q;
   assign bus.spi_mosi           = mosi_q;
   assign bus.spi_cs_n           = csN_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed + randomized bench for spi_master_core: loopback and a shift-register slave model on the
// default instance, plus a CPOL=1/CPHA=1/CLK_DIV=1 instance for back-to-back frames.
module tb_spi_master_core;

   localparam int DW   = 32;
   localparam int LAT1 = 1 + 2 + 2 * DW * 4 + 2;
   localparam int LAT2 = 1 + 2 + 2 * DW * 1 + 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          checkCount = 0;
   int          failCount = 0;
   int          fallCnt = 0;
   int          fallCnt2 = 0;
   int          riseCnt = 0;
   bit          loopMode = 1'b1;
   logic [31:0] slaveWord = '0;
   logic [31:0] slaveSr = '0;
   logic [31:0] mosiCap = '0;
   logic        slaveBit = 1'b0;

   spi_master_core_if #(.DATA_W(DW)) bus ();
   spi_master_core_if #(.DATA_W(DW)) bus2 ();

   assign bus.spi_miso  = loopMode ? bus.spi_mosi : slaveBit;
   assign bus2.spi_miso = bus2.spi_mosi;

   spi_master_core #(
      .DATA_W(DW), .CLK_DIV(4), .CPOL(0), .CPHA(0), .CS_SETUP(2), .CS_HOLD(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   spi_master_core #(
      .DATA_W(DW), .CLK_DIV(1), .CPOL(1), .CPHA(1), .CS_SETUP(2), .CS_HOLD(2)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2)
   );

   always #5 clk = ~clk;

   // Completion edges only count while out of reset; reset pulls ready low without completing.
   always @(negedge bus.data_pack_ready) if (reset_n) fallCnt++;
   always @(negedge bus2.data_pack_ready) if (reset_n) fallCnt2++;

   // Mode-0 slave: MSB ready at cs_n fall, next bit on each falling sclk; capture mosi on rising sclk.
   always @(negedge bus.spi_cs_n) begin
      slaveSr  = slaveWord;
      slaveBit = slaveSr[31];
      mosiCap  = '0;
   end
   always @(negedge bus.spi_sclk) begin
      if (!bus.spi_cs_n) begin
         slaveSr  = {slaveSr[30:0], 1'b0};
         slaveBit = slaveSr[31];
      end
   end
   always @(posedge bus.spi_sclk) begin
      if (!bus.spi_cs_n) begin
         mosiCap = {mosiCap[30:0], bus.spi_mosi};
         riseCnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic setGo(input bit which, input logic go, input logic [31:0] data);
      if (which) begin
         bus2.go_transfer       = go;
         bus2.data_write_to_spi = data;
      end else begin
         bus.go_transfer       = go;
         bus.data_write_to_spi = data;
      end
   endtask

   // Starts at the current time (caller stays away from the edge), returns #1 after completion.
   task automatic applyStimulus(input bit which, input logic [31:0] tx, input bit repulse,
                                output int lat, output logic [31:0] rx);
      int n;
      logic rdy;
      setGo(which, 1'b1, tx);
      @(posedge clk);
      #1;
      setGo(which, 1'b0, ~tx);
      rdy = which ? bus2.data_pack_ready : bus.data_pack_ready;
      checkOutput("accept_ready", {31'd0, rdy}, 32'd1);
      n = 0;
      while (n < 400) begin
         @(posedge clk);
         n++;
         #1;
         setGo(which, repulse && (n == 1 || n == 100 || n == 260), $urandom);
         rdy = which ? bus2.data_pack_ready : bus.data_pack_ready;
         if (!rdy) break;
      end
      setGo(which, 1'b0, '0);
      lat = n;
      rx  = which ? bus2.data_read_from_spi : bus.data_read_from_spi;
   endtask

   initial begin
      int          lat;
      int          fallBefore;
      logic [31:0] rx;
      logic [31:0] tx;

      // Reset behaviour, with go held high during reset
      setGo(1'b0, 1'b1, 32'hFFFF_FFFF);
      setGo(1'b1, 1'b1, 32'hFFFF_FFFF);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
      checkOutput("rst_sclk", {31'd0, bus.spi_sclk}, 32'd0);
      checkOutput("rst_mosi", {31'd0, bus.spi_mosi}, 32'd0);
      checkOutput("rst_ready", {31'd0, bus.data_pack_ready}, 32'd0);
      checkOutput("rst_rx", bus.data_read_from_spi, 32'd0);
      checkOutput("rst_sclk2", {31'd0, bus2.spi_sclk}, 32'd1);
      setGo(1'b0, 1'b0, '0);
      setGo(1'b1, 1'b0, '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("post_rst_idle_ready", {31'd0, bus.data_pack_ready}, 32'd0);
      checkOutput("post_rst_idle_cs", {31'd0, bus.spi_cs_n}, 32'd1);

      // Loopback A5A5A5A5
      loopMode = 1'b1;
      @(negedge clk);
      riseCnt = 0;
      applyStimulus(1'b0, 32'hA5A5_A5A5, 1'b0, lat, rx);
      checkOutput("loop_rx", rx, 32'hA5A5_A5A5);
      checkOutput("loop_lat", lat, LAT1);
      checkOutput("loop_rises", riseCnt, 32'd32);
      checkOutput("loop_sclk_idle", {31'd0, bus.spi_sclk}, 32'd0);
      checkOutput("loop_cs_idle", {31'd0, bus.spi_cs_n}, 32'd1);

      // Slave returns 12345678 while master sends DEADBEEF
      loopMode  = 1'b0;
      slaveWord = 32'h1234_5678;
      @(negedge clk);
      applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, lat, rx);
      checkOutput("slave_rx", rx, 32'h1234_5678);
      checkOutput("slave_mosi", mosiCap, 32'hDEAD_BEEF);

      // Randomized frames against the slave model
      for (int i = 0; i < 4; i++) begin
         slaveWord = $urandom;
         tx        = $urandom;
         @(negedge clk);
         riseCnt = 0;
         applyStimulus(1'b0, tx, 1'b0, lat, rx);
         checkOutput("rand_rx", rx, slaveWord);
         checkOutput("rand_mosi", mosiCap, tx);
         checkOutput("rand_lat", lat, LAT1);
         checkOutput("rand_rises", riseCnt, 32'd32);
      end

      // go re-pulsed during SETUP, SHIFT and HOLD must be ignored
      loopMode = 1'b1;
      tx = $urandom;
      fallBefore = fallCnt;
      @(negedge clk);
      applyStimulus(1'b0, tx, 1'b1, lat, rx);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("repulse_rx", rx, tx);
      checkOutput("repulse_lat", lat, LAT1);
      checkOutput("repulse_falls", fallCnt - fallBefore, 32'd1);
      checkOutput("repulse_no_second", {31'd0, bus.data_pack_ready}, 32'd0);

      // Reset at bit 10 aborts the frame
      fallBefore = fallCnt;
      riseCnt = 0;
      @(negedge clk);
      setGo(1'b0, 1'b1, $urandom);
      @(posedge clk);
      #1;
      setGo(1'b0, 1'b0, '0);
      for (int n = 0; n < 500 && riseCnt < 10; n++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort_reached_bit10", riseCnt, 32'd10);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
      checkOutput("abort_sclk", {31'd0, bus.spi_sclk}, 32'd0);
      checkOutput("abort_rx", bus.data_read_from_spi, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("abort_no_completion", fallCnt - fallBefore, 32'd0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0000_FFFF, 1'b0, lat, rx);
      checkOutput("after_abort_rx", rx, 32'h0000_FFFF);
      checkOutput("after_abort_lat", lat, LAT1);

      // CPOL=1 CPHA=1 CLK_DIV=1 instance, back-to-back frames
      checkOutput("mode3_sclk_idle", {31'd0, bus2.spi_sclk}, 32'd1);
      fallBefore = fallCnt2;
      @(negedge clk);
      applyStimulus(1'b1, 32'h8000_0001, 1'b0, lat, rx);
      checkOutput("mode3_rx_a", rx, 32'h8000_0001);
      checkOutput("mode3_lat_a", lat, LAT2);
      checkOutput("mode3_sclk_end", {31'd0, bus2.spi_sclk}, 32'd1);
      applyStimulus(1'b1, 32'h7FFF_FFFE, 1'b0, lat, rx);
      checkOutput("mode3_rx_b", rx, 32'h7FFF_FFFE);
      checkOutput("mode3_lat_b", lat, LAT2);
      checkOutput("mode3_falls", fallCnt2 - fallBefore, 32'd2);

      $display("test done: total=%0d bad=%0d", checkCount, failCount);
      $finish;
   end

endmodule
